// File: rtl/sl_perceptron_top.sv
// ---------------------------------------------------------------------------
// sl_perceptron_top
//
// Single-layer perceptron accelerator. One weight vector lives in a small
// memory-mapped register array. A data vector is streamed in DATA_IN_LANES
// elements per beat, and the dot product of data and weights is accumulated.
// When the vector completes, the sum and a threshold comparison are published
// on the status outputs, where they hold until the next vector completes.
//
// Ports
//   clk                   single clock, rising edge
//   rst_n                 synchronous reset, active HIGH despite the name
//   data_valid / data_in  streaming data beat; lane i = data_in[8i+7:8i]
//   mem_wen / mem_ren     weight write / read strobes
//   mem_addr              byte address; weight 0 sits at SRAM_BASE_ADDRESS
//   mem_wdata / mem_rdata weight write data / registered read data
//   cfg_ai_threshold      comparator threshold, sampled when a vector finishes
//   status_ai_sum         last completed dot product
//   status_ai_comparator  1 when status_ai_sum > cfg_ai_threshold
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// sl_perceptron_mac
//
// Dot-product engine and its control FSM. The incoming beat is registered
// once before it reaches the multipliers, so the last beat sampled at edge T
// is folded into the accumulator at T+1, published at T+2, and the two-clock
// delayed state (c_state_del2) reads DONE after T+4.
//
// Ports
//   clk, srst        clock and synchronous active-high reset
//   beat_valid       data beat valid this cycle
//   beat_data        DATA_IN_LANES packed unsigned elements
//   weights          full weight vector (read combinationally per lane)
//   threshold        comparator threshold
//   sum_out          last completed dot product
//   comp_out         sum_out > threshold, strict
// ---------------------------------------------------------------------------
module sl_perceptron_mac #(
  parameter int DATA_IN_LANES = 4,
  parameter int DATA_IN_WIDTH = 8,
  parameter int WEIGHTS_WIDTH = 8,
  parameter int VECTOR_LENGTH = 64,
  parameter int SUM_WIDTH     = 22
) (
  input  logic                                   clk,
  input  logic                                   srst,
  input  logic                                   beat_valid,
  input  logic [DATA_IN_LANES*DATA_IN_WIDTH-1:0] beat_data,
  input  logic [WEIGHTS_WIDTH-1:0]               weights [VECTOR_LENGTH],
  input  logic [SUM_WIDTH-1:0]                   threshold,
  output logic [SUM_WIDTH-1:0]                   sum_out,
  output logic                                   comp_out
);

  localparam int BEATS = VECTOR_LENGTH / DATA_IN_LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
  localparam int PROD_W = DATA_IN_WIDTH + WEIGHTS_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Registered input beat
  logic                                   beat_valid_q, beat_valid_d;
  logic [DATA_IN_LANES*DATA_IN_WIDTH-1:0] beat_data_q, beat_data_d;

  // Datapath / control state
  state_t                 state_q, state_d;
  logic [SUM_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SUM_WIDTH-1:0]   sum_q, sum_d;
  logic                   comp_q, comp_d;

  // State history; c_state_del2 is the externally observed result-ready tap
  state_t                 state_del1_q;
  state_t                 c_state_del2;

  // Per-lane products
  logic [IDX_W-1:0]       lane_idx [DATA_IN_LANES];
  logic [PROD_W-1:0]      lane_prod [DATA_IN_LANES];
  logic [SUM_WIDTH-1:0]   partial;

  // Beat k uses weights k*LANES .. k*LANES+LANES-1; cnt_q is k for the beat
  // currently sitting in the input register.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_IN_LANES; gi++) begin : g_lane
      logic [DATA_IN_WIDTH-1:0] lane_data;
      assign lane_data     = beat_data_q[gi*DATA_IN_WIDTH +: DATA_IN_WIDTH];
      assign lane_idx[gi]  = IDX_W'(int'(cnt_q) * DATA_IN_LANES + gi);
      assign lane_prod[gi] = PROD_W'(lane_data) * PROD_W'(weights[lane_idx[gi]]);
    end
  endgenerate

  always_comb begin
    partial = '0;
    for (int i = 0; i < DATA_IN_LANES; i++) begin
      partial = partial + SUM_WIDTH'(lane_prod[i]);
    end
  end

  always_comb begin
    beat_valid_d = beat_valid;
    beat_data_d  = beat_data;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    comp_d  = comp_q;
    case (state_q)
      IDLE: begin
        if (beat_valid_q) begin
          acc_d   = partial;
          cnt_d   = CNT_W'(1);
          state_d = (BEATS == 1) ? FINAL : ACC;
        end
      end
      ACC: begin
        // Gaps in the stream simply hold the accumulator in place
        if (beat_valid_q) begin
          acc_d = acc_q + partial;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            state_d = FINAL;
          end
        end
      end
      FINAL: begin
        sum_d   = acc_q;
        comp_d  = (acc_q > threshold);
        state_d = DONE;
      end
      DONE: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      beat_valid_q <= 1'b0;
      beat_data_q  <= '0;
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      sum_q        <= '0;
      comp_q       <= 1'b0;
      state_del1_q <= IDLE;
      c_state_del2 <= IDLE;
    end else begin
      beat_valid_q <= beat_valid_d;
      beat_data_q  <= beat_data_d;
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      comp_q       <= comp_d;
      state_del1_q <= state_q;
      c_state_del2 <= state_del1_q;
    end
  end

  // DONE always returns to IDLE, so the delayed tap can only read DONE one
  // cycle after the single-delayed copy has moved on to IDLE.
  a_done_then_idle: assert property (@(posedge clk) disable iff (srst)
    (c_state_del2 == DONE) |-> (state_del1_q == IDLE));

  assign sum_out  = sum_q;
  assign comp_out = comp_q;

endmodule

module sl_perceptron_top #(
  parameter int          DATA_IN_LANES     = 4,
  parameter int          DATA_IN_WIDTH     = 8,
  parameter int          MEM_ADDR_WIDTH    = 16,
  parameter int          WEIGHTS_WIDTH     = 8,
  parameter int          VECTOR_LENGTH     = 64,
  parameter int          SUM_WIDTH         = 22,
  parameter int unsigned SRAM_BASE_ADDRESS = 'h1000
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   data_valid,
  input  logic [DATA_IN_LANES*DATA_IN_WIDTH-1:0] data_in,
  input  logic                                   mem_wen,
  input  logic                                   mem_ren,
  input  logic [MEM_ADDR_WIDTH-1:0]              mem_addr,
  input  logic [WEIGHTS_WIDTH-1:0]               mem_wdata,
  output logic [WEIGHTS_WIDTH-1:0]               mem_rdata,
  input  logic [SUM_WIDTH-1:0]                   cfg_ai_threshold,
  output logic [SUM_WIDTH-1:0]                   status_ai_sum,
  output logic                                   status_ai_comparator
);

  localparam int IDX_W = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;

  // rst_n is active high; give it an honest name internally
  logic srst;
  assign srst = rst_n;

  // Weight storage: plain registers so every lane can read in parallel.
  // Deliberately not reset; weights survive a reset of the engine.
  logic [WEIGHTS_WIDTH-1:0] weight_q [VECTOR_LENGTH];

  logic [MEM_ADDR_WIDTH-1:0] addr_off;
  logic                      addr_ok;
  logic [IDX_W-1:0]          mem_idx;
  logic [WEIGHTS_WIDTH-1:0]  rdata_q, rdata_d;

  // Window check done on the full address so addresses below the base or
  // beyond the vector never alias onto a real weight.
  assign addr_off = mem_addr - MEM_ADDR_WIDTH'(SRAM_BASE_ADDRESS);
  assign addr_ok  = (mem_addr >= MEM_ADDR_WIDTH'(SRAM_BASE_ADDRESS)) &&
                    (addr_off < MEM_ADDR_WIDTH'(VECTOR_LENGTH));
  assign mem_idx  = addr_off[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (mem_wen && addr_ok) begin
      weight_q[mem_idx] <= mem_wdata;
    end
  end

  // Registered read; a simultaneous write to the same index returns the old
  // contents because both sample weight_q before the edge updates it.
  always_comb begin
    rdata_d = rdata_q;
    if (mem_ren) begin
      rdata_d = addr_ok ? weight_q[mem_idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign mem_rdata = rdata_q;

  sl_perceptron_mac #(
    .DATA_IN_LANES (DATA_IN_LANES),
    .DATA_IN_WIDTH (DATA_IN_WIDTH),
    .WEIGHTS_WIDTH (WEIGHTS_WIDTH),
    .VECTOR_LENGTH (VECTOR_LENGTH),
    .SUM_WIDTH     (SUM_WIDTH)
  ) mac_processor (
    .clk        (clk),
    .srst       (srst),
    .beat_valid (data_valid),
    .beat_data  (data_in),
    .weights    (weight_q),
    .threshold  (cfg_ai_threshold),
    .sum_out    (status_ai_sum),
    .comp_out   (status_ai_comparator)
  );

endmodule

// File: tb/tb_sl_perceptron_top.sv
// ---------------------------------------------------------------------------
// tb_sl_perceptron_top
//
// Scoreboard bench for sl_perceptron_top. Each full vector pushes its
// expected sum/comparator (computed from a bench-side weight model) when
// driven; the monitor pops and compares whenever the engine signals a
// finished result. Weight reads are compared one cycle after the strobe.
// ---------------------------------------------------------------------------
module tb_sl_perceptron_top;

  localparam int L     = 4;
  localparam int DW    = 8;
  localparam int VL    = 64;
  localparam int SW    = 22;
  localparam int BEATS = VL / L;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          data_valid;
  logic [L*DW-1:0] data_in;
  logic          mem_wen;
  logic          mem_ren;
  logic [15:0]   mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic [SW-1:0] cfg_ai_threshold;
  logic [SW-1:0] status_ai_sum;
  logic          status_ai_comparator;

  always #5 clk = ~clk;

  sl_perceptron_top dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .data_valid           (data_valid),
    .data_in              (data_in),
    .mem_wen              (mem_wen),
    .mem_ren              (mem_ren),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_rdata            (mem_rdata),
    .cfg_ai_threshold     (cfg_ai_threshold),
    .status_ai_sum        (status_ai_sum),
    .status_ai_comparator (status_ai_comparator)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] w_model  [VL];
  logic [7:0] vec_data [VL];

  typedef struct packed {
    logic [SW-1:0] sum;
    logic          comp;
  } exp_t;
  exp_t exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Result monitor: pop the oldest expectation whenever a result is ready
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n == 1'b0 && dut.mac_processor.c_state_del2 == 2'd3) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_result", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("sum", 32'(status_ai_sum), 32'(mon_e.sum));
        check_val("comp", 32'(status_ai_comparator), 32'(mon_e.comp));
        $display("result: sum=%0d comp=%0d (expected %0d/%0d)",
                 status_ai_sum, status_ai_comparator, mon_e.sum, mon_e.comp);
      end
    end
  end

  task automatic do_reset(input int cycles);
    rst_n = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    int idx;
    mem_wen   = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    @(posedge clk);
    #1;
    mem_wen = 1'b0;
    idx = int'(a) - 'h1000;
    if (idx >= 0 && idx < VL) w_model[idx] = d;
  endtask

  task automatic rd_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
    mem_ren  = 1'b1;
    mem_addr = a;
    @(posedge clk);
    #1;
    mem_ren = 1'b0;
    check_val(tag, 32'(mem_rdata), 32'(exp));
  endtask

  // Drive n_beats beats of vec_data; optional stall of gap_len cycles after
  // beat gap_after. A full vector pushes its expected result first.
  task automatic send_vec(input bit push, input int n_beats, input int gap_after, input int gap_len);
    int   s;
    exp_t e;
    if (push) begin
      s = 0;
      for (int i = 0; i < VL; i++) s += int'(vec_data[i]) * int'(w_model[i]);
      e.sum  = SW'(s);
      e.comp = (SW'(s) > cfg_ai_threshold);
      exp_q.push_back(e);
    end
    for (int k = 0; k < n_beats; k++) begin
      for (int i = 0; i < L; i++) data_in[i*DW +: DW] = vec_data[k*L + i];
      data_valid = 1'b1;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      if (k == gap_after) begin
        repeat (gap_len) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_results();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      check_val("result_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n            = 1'b1;
    data_valid       = 1'b0;
    data_in          = '0;
    mem_wen          = 1'b0;
    mem_ren          = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    cfg_ai_threshold = '0;
    for (int i = 0; i < VL; i++) w_model[i] = 8'h00;

    // Reset
    do_reset(2);
    check_val("rst_sum", 32'(status_ai_sum), 32'd0);
    check_val("rst_comp", 32'(status_ai_comparator), 32'd0);
    check_val("rst_rdata", 32'(mem_rdata), 32'd0);
    check_val("rst_state", 32'(dut.mac_processor.state_q), 32'd0);
    check_val("rst_del2", 32'(dut.mac_processor.c_state_del2), 32'd0);

    // Weight write / readback
    for (int i = 0; i < VL; i++) wr(16'(32'h1000 + i), 8'(i));
    for (int i = 0; i < VL; i++) rd_check("readback", 16'(32'h1000 + i), w_model[i]);
    rd_check("rd_below", 16'h0FFF, 8'd0);
    rd_check("rd_above", 16'h1040, 8'd0);
    rd_check("rd_3", 16'h1003, 8'd3);
    mem_addr = 16'h1007;
    @(posedge clk);
    #1;
    check_val("rd_hold", 32'(mem_rdata), 32'd3);
    wr(16'h1040, 8'hAA);
    wr(16'h0FFF, 8'hBB);
    rd_check("oor_wr_ignored", 16'h1000, w_model[0]);
    // Same-index write and read: old data returned, new data stored
    mem_wen = 1'b1; mem_ren = 1'b1; mem_addr = 16'h1005; mem_wdata = 8'd200;
    @(posedge clk);
    #1;
    mem_wen = 1'b0; mem_ren = 1'b0;
    check_val("rw_old", 32'(mem_rdata), 32'd5);
    w_model[5] = 8'd200;
    rd_check("rw_new", 16'h1005, 8'd200);

    // All-ones dot product, strict threshold
    for (int i = 0; i < VL; i++) wr(16'(32'h1000 + i), 8'd1);
    for (int i = 0; i < VL; i++) vec_data[i] = 8'd1;
    cfg_ai_threshold = SW'(63);
    send_vec(1'b1, BEATS, -1, 0);
    wait_results();
    cfg_ai_threshold = SW'(64);
    send_vec(1'b1, BEATS, -1, 0);
    wait_results();

    // Max values
    for (int i = 0; i < VL; i++) wr(16'(32'h1000 + i), 8'd255);
    for (int i = 0; i < VL; i++) vec_data[i] = 8'd255;
    cfg_ai_threshold = SW'(4161599);
    send_vec(1'b1, BEATS, -1, 0);
    wait_results();
    check_val("max_sum_abs", 32'(status_ai_sum), 32'd4161600);

    // Gapped stream, lane order: sum of i^2
    for (int i = 0; i < VL; i++) wr(16'(32'h1000 + i), 8'(i));
    for (int i = 0; i < VL; i++) vec_data[i] = 8'(i);
    cfg_ai_threshold = SW'(100000);
    send_vec(1'b1, BEATS, 7, 3);
    wait_results();
    check_val("sq_sum_abs", 32'(status_ai_sum), 32'd85344);

    // Back-to-back vectors with rewritten weights
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < VL; i++) wr(16'(32'h1000 + i), 8'($urandom_range(0, 255)));
      for (int i = 0; i < VL; i++) vec_data[i] = 8'($urandom_range(0, 255));
      cfg_ai_threshold = SW'($urandom_range(0, 2000000));
      send_vec(1'b1, BEATS, -1, 0);
    end
    wait_results();

    // Abort mid-vector with reset, then a clean vector
    for (int i = 0; i < VL; i++) vec_data[i] = 8'($urandom_range(0, 255));
    send_vec(1'b0, 8, -1, 0);
    do_reset(2);
    check_val("abort_sum", 32'(status_ai_sum), 32'd0);
    check_val("abort_comp", 32'(status_ai_comparator), 32'd0);
    for (int i = 0; i < VL; i++) vec_data[i] = 8'($urandom_range(0, 255));
    cfg_ai_threshold = SW'(1000000);
    send_vec(1'b1, BEATS, 3, 2);
    wait_results();

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sl_perceptron_top.md
Name: sl_perceptron_top

Overview:
- Single-layer perceptron accelerator. Stores one weight vector in a memory-mapped weight RAM.
- Consumes an input vector streamed in multiple lanes per beat and accumulates the dot product of data and weights.
- Publishes the sum, plus a threshold-comparator result, on status outputs.
- Sits behind a simple memory-write bus (weights), a streaming data port, and a config/status register interface.

Parameters:
- DATA_IN_LANES, 4, data elements delivered per valid beat
- DATA_IN_WIDTH, 8, bits per data element (unsigned)
- MEM_ADDR_WIDTH, 16, weight-bus address width
- WEIGHTS_WIDTH, 8, bits per weight (unsigned)
- VECTOR_LENGTH, 64, elements per vector; must be a multiple of DATA_IN_LANES
- SUM_WIDTH, 22, accumulator/status width (DATA_IN_WIDTH+WEIGHTS_WIDTH+clog2(VECTOR_LENGTH))
- SRAM_BASE_ADDRESS, 'h1000, byte address of weight 0

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-high (asserted = 1 despite the suffix)
- data_valid  in  1  data_in beat valid this cycle
- data_in  in  DATA_IN_LANES*DATA_IN_WIDTH  lane i = bits [8i+7:8i]
- mem_wen  in  1  weight write strobe
- mem_ren  in  1  weight read strobe
- mem_addr  in  MEM_ADDR_WIDTH  weight address
- mem_wdata  in  WEIGHTS_WIDTH  write data
- mem_rdata  out  WEIGHTS_WIDTH  read data
- cfg_ai_threshold  in  SUM_WIDTH  comparator threshold
- status_ai_sum  out  SUM_WIDTH  last completed dot product
- status_ai_comparator  out  1  1 when status_ai_sum > threshold

Behaviour:
- Reset (rst_n=1 at a clock edge):
  - state=IDLE, accumulator=0, beat counter=0.
  - status_ai_sum=0, status_ai_comparator=0, mem_rdata=0.
  - Weight array contents are not cleared.
- Weight RAM: VECTOR_LENGTH x WEIGHTS_WIDTH registers. Index = mem_addr - SRAM_BASE_ADDRESS, valid when in [0, VECTOR_LENGTH).
  - Write: mem_wen=1 with a valid index writes mem_wdata at that edge.
  - Out-of-range writes are ignored.
  - Read: mem_ren=1 registers the array[index] into mem_rdata (1-cycle latency). Out-of-range reads return 0. mem_rdata holds when mem_ren=0.
  - mem_wen and mem_ren together at the same index: the write takes effect and the read returns the old value.
- MAC: instance named mac_processor.
  - Beat k (k-th accepted beat, 0-based) pairs lane i with weight[k*DATA_IN_LANES+i].
  - Partial = sum over lanes of the unsigned products (16-bit products).
  - Accumulator is SUM_WIDTH, unsigned, wraps modulo 2^SUM_WIDTH; no overflow occurs at the defaults.
- FSM, encoding IDLE=0, ACC=1, FINAL=2, DONE=3:
  - IDLE: on data_valid, acc<=partial, cnt<=1, go to ACC. If VECTOR_LENGTH==DATA_IN_LANES, go directly to FINAL.
  - ACC: on data_valid, acc<=acc+partial, cnt++. Go to FINAL when the beat accepted is beat VECTOR_LENGTH/DATA_IN_LANES-1. data_valid=0 stalls in place (gaps allowed).
  - FINAL: status_ai_sum<=acc; status_ai_comparator<=(acc > cfg_ai_threshold), strict, threshold sampled this cycle; go to DONE.
  - DONE: acc<=0, cnt<=0, go to IDLE.
  - data_valid in FINAL/DONE is ignored (dropped).
- Status outputs hold until the next FINAL.
- mac_processor contains register c_state_del2 = FSM state delayed by two clocks (reset 0). Benches use c_state_del2==3 as the result-ready indication. The status outputs are stable when it asserts.
- Latency: the last beat sampled at edge T gives status updated at T+2 and c_state_del2==3 at T+4.
- Weight writes during accumulation take effect for beats that have not yet been consumed.
- Reset mid-vector aborts the vector and clears the partial sum.

Test Plan:
- Reset:
  - Hold rst_n=1 for 2 cycles → status_ai_sum=0, comparator=0, mem_rdata=0, state IDLE.
- Weight write/readback:
  - Write weight[i]=i at 0x1000+i for i=0..63.
  - Read back 0x1000..0x103F → mem_rdata=i one cycle after each ren.
  - Read 0x0FFF → 0.
- All-ones dot product:
  - weights all 1; 16 beats with every data lane = 1; threshold=63 → sum=64, comp=1.
  - Rerun with threshold=64 → comp=0 (strict).
- Max values:
  - weights=255, data=255 → sum=4161600, no wrap.
  - threshold=4161599 → comp=1.
- Gapped stream and lane order:
  - weight[i]=i; data lane values = index; deassert data_valid for 3 cycles mid-vector → sum=Σi²=85344.
  - Result is unaffected by the gaps.
- Back-to-back vectors and abort:
  - Five vectors with rewritten weights each produce independent correct sums.
  - Reset after 8 beats, then a full vector → only the post-reset vector is summed.
